// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux select sequencer.
package mux_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    localparam int unsigned NUM_CH = 4;

    // Dwell counter width; a single-clock dwell still needs one bit of storage.
    function automatic int unsigned cnt_w(input int unsigned dwell);
        if (dwell <= 32'd2) begin
            return 32'd1;
        end
        return $clog2(dwell);
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Combinational round-robin search: next enabled channel strictly above cur, wrapping 3->0.
module rr_next_sel (
    input  logic [1:0] cur,
    input  logic [3:0] mask,
    output logic [1:0] nxt,
    output logic       wraps
);

    logic [1:0] cand;

    // Scan farthest-first so the nearest enabled channel is the last to win.
    always_comb begin
        nxt  = cur;
        cand = cur;
        for (int k = 3; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (mask[cand]) begin
                nxt = cand;
            end
        end
        wraps = (nxt <= cur);
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Drives a 4:1 word mux: loadable channel register bank plus a dwell-timed round-robin
// select that walks only the enabled channels.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned M     = 4,
    parameter int unsigned DWELL = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [3:0]   ch_mask,
    input  logic         load,
    input  logic [1:0]   load_ch,
    input  logic [M-1:0] load_data,
    output logic [M-1:0] I0,
    output logic [M-1:0] I1,
    output logic [M-1:0] I2,
    output logic [M-1:0] I3,
    output logic [1:0]   S,
    output logic         step,
    output logic         wrap,
    output logic         busy
);

    localparam int unsigned   CW       = cnt_w(DWELL);
    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

    seq_state_e    state;
    logic [CW-1:0] dwell_cnt;
    logic          run_ok;
    logic          cur_off;
    logic          at_last;
    logic          entry_jump;
    logic [1:0]    rr_cur;
    logic [1:0]    nxt_sel;
    logic          nxt_wraps;

    assign run_ok     = en && (ch_mask != 4'b0000);
    assign cur_off    = ~ch_mask[S];
    assign at_last    = (dwell_cnt == LAST_CNT);
    assign entry_jump = (state == IDLE) && cur_off;
    // Searching above index 3 returns the lowest enabled channel.
    assign rr_cur     = entry_jump ? 2'd3 : S;

    rr_next_sel u_rr_next_sel (
        .cur   (rr_cur),
        .mask  (ch_mask),
        .nxt   (nxt_sel),
        .wraps (nxt_wraps)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            S         <= 2'b00;
            dwell_cnt <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_ok) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run_ok) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // The entry cycle counts too, so a frozen dwell resumes where it stopped.
            if (run_ok) begin
                if (cur_off || at_last) begin
                    S         <= nxt_sel;
                    dwell_cnt <= '0;
                    step      <= 1'b1;
                    wrap      <= nxt_wraps && !entry_jump;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            I0 <= '0;
            I1 <= '0;
            I2 <= '0;
            I3 <= '0;
        end else if (load) begin
            unique case (load_ch)
                2'd0: I0 <= load_data;
                2'd1: I1 <= load_data;
                2'd2: I2 <= load_data;
                2'd3: I3 <= load_data;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// against a behavioural rotation model, for DWELL=4 and a DWELL=1 companion instance.
module tb_mux_sel_sequencer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] ch_mask;
    logic       load;
    logic [1:0] load_ch;
    logic [3:0] load_data;

    logic [3:0] I0, I1, I2, I3;
    logic [1:0] S;
    logic       step, wrap, busy;
    logic [3:0] J0, J1, J2, J3;
    logic [1:0] S1;
    logic       step1, wrap1, busy1;
    logic [3:0] dut_o;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    mux_sel_sequencer #(.M(4), .DWELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .load(load),
        .load_ch(load_ch), .load_data(load_data), .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .S(S), .step(step), .wrap(wrap), .busy(busy)
    );

    mux_sel_sequencer #(.M(4), .DWELL(1)) u_dut_d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .load(load),
        .load_ch(load_ch), .load_data(load_data), .I0(J0), .I1(J1), .I2(J2), .I3(J3),
        .S(S1), .step(step1), .wrap(wrap1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always_comb begin
        dut_o = I0;
        case (S)
            2'd1: dut_o = I1;
            2'd2: dut_o = I2;
            2'd3: dut_o = I3;
            default: dut_o = I0;
        endcase
    end

    // Behavioural model of the rotation.
    typedef struct packed {
        logic [1:0] s;
        logic [7:0] cnt;
        logic       run;
        logic       step;
        logic       wrap;
    } mst_t;

    mst_t       m4, m1;
    logic [3:0] m_i [4];

    function automatic logic [1:0] next_above(input logic [1:0] cur, input logic [3:0] mask);
        for (int d = 1; d <= 4; d++) begin
            if (mask[(int'(cur) + d) % 4]) return 2'((int'(cur) + d) % 4);
        end
        return cur;
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic mst_t model_step(input mst_t m, input int dwell, input logic en_v,
                                        input logic [3:0] mask_v);
        mst_t n;
        n      = m;
        n.step = 1'b0;
        n.wrap = 1'b0;
        if (!en_v || mask_v == 4'b0000) begin
            n.run = 1'b0;
        end else begin
            n.run = 1'b1;
            if (!mask_v[m.s]) begin
                n.s    = m.run ? next_above(m.s, mask_v) : lowest(mask_v);
                n.cnt  = 8'd0;
                n.step = 1'b1;
                n.wrap = m.run && (n.s <= m.s);
            end else if (int'(m.cnt) == dwell - 1) begin
                n.s    = next_above(m.s, mask_v);
                n.cnt  = 8'd0;
                n.step = 1'b1;
                n.wrap = (n.s <= m.s);
            end else begin
                n.cnt = m.cnt + 8'd1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 <= '0;
            m1 <= '0;
            for (int i = 0; i < 4; i++) m_i[i] <= 4'd0;
        end else begin
            m4 <= model_step(m4, 4, en, ch_mask);
            m1 <= model_step(m1, 1, en, ch_mask);
            if (load) m_i[load_ch] <= load_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (cmp_on) begin
            chk("S", 32'(S), 32'(m4.s));
            chk("step", 32'(step), 32'(m4.step));
            chk("wrap", 32'(wrap), 32'(m4.wrap));
            chk("busy", 32'(busy), 32'(m4.run));
            chk("I0", 32'(I0), 32'(m_i[0]));
            chk("I1", 32'(I1), 32'(m_i[1]));
            chk("I2", 32'(I2), 32'(m_i[2]));
            chk("I3", 32'(I3), 32'(m_i[3]));
            chk("O", 32'(dut_o), 32'(m_i[m4.s]));
            chk("d1_S", 32'(S1), 32'(m1.s));
            chk("d1_step", 32'(step1), 32'(m1.step));
            chk("d1_wrap", 32'(wrap1), 32'(m1.wrap));
            chk("d1_busy", 32'(busy1), 32'(m1.run));
            chk("d1_I", 32'({J3, J2, J1, J0}), 32'({m_i[3], m_i[2], m_i[1], m_i[0]}));
        end
    end

    // Called at a negedge; waits for the model to reach a given select/dwell position.
    task automatic wait_model(input logic [1:0] s, input int c, input string tag);
        int n = 0;
        while (!(m4.s == s && int'(m4.cnt) == c) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk({tag, "_timeout"}, 32'(n), 32'd0);
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b1; en = 1'b0; ch_mask = 4'b0000;
        load = 1'b0; load_ch = 2'd0; load_data = 4'd0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_I", 32'({I3, I2, I1, I0}), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Test 1: full rotation over Ik = k.
        for (int k = 0; k < 4; k++) begin
            load = 1'b1; load_ch = 2'(k); load_data = 4'(k);
            @(negedge clk);
        end
        load = 1'b0; ch_mask = 4'b1111; en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #2;
            chk("t1_S", 32'(S), 32'((k / 4) % 4));
            chk("t1_O", 32'(dut_o), 32'((k / 4) % 4));
            chk("t1_step", 32'(step), 32'(k % 4 == 0));
            chk("t1_wrap", 32'(wrap), 32'(k == 16));
            if (k <= 4) chk("t1_d1_S", 32'(S1), 32'(k % 4));
        end

        // Test 2: only channels 1 and 3.
        @(negedge clk);
        ch_mask = 4'b1010;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #2;
            chk("t2_S", 32'(S), (((e - 1) / 4) % 2 == 0) ? 32'd1 : 32'd3);
            chk("t2_O", 32'(dut_o), (((e - 1) / 4) % 2 == 0) ? 32'd1 : 32'd3);
            chk("t2_step", 32'(step), 32'(e % 4 == 1));
            chk("t2_wrap", 32'(wrap), 32'(e == 9));
        end

        // Test 3: freeze at dwell 2 on S=2.
        @(negedge clk);
        ch_mask = 4'b1111;
        wait_model(2'd2, 2, "t3");
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            chk("t3_hold_S", 32'(S), 32'd2);
            chk("t3_hold_O", 32'(dut_o), 32'd2);
            chk("t3_hold_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #2;
        chk("t3_r1_S", 32'(S), 32'd2);
        chk("t3_r1_step", 32'(step), 32'd0);
        @(posedge clk);
        #2;
        chk("t3_r2_S", 32'(S), 32'd3);
        chk("t3_r2_step", 32'(step), 32'd1);

        // Test 4: overwrite the selected channel.
        @(negedge clk);
        wait_model(2'd1, 1, "t4");
        load = 1'b1; load_ch = 2'd1; load_data = 4'b1000;
        @(posedge clk);
        #2;
        chk("t4_O", 32'(dut_o), 32'b1000);
        chk("t4_S", 32'(S), 32'd1);
        @(negedge clk);
        load = 1'b0;

        // Test 5: current channel masked off right after arriving.
        wait_model(2'd1, 0, "t5");
        ch_mask = 4'b1101;
        @(posedge clk);
        #2;
        chk("t5_S", 32'(S), 32'd2);
        chk("t5_step", 32'(step), 32'd1);
        chk("t5_wrap", 32'(wrap), 32'd0);

        // Test 6: asynchronous reset mid-dwell on S=3.
        @(negedge clk);
        ch_mask = 4'b1111;
        wait_model(2'd3, 1, "t6");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_S", 32'(S), 32'd0);
        chk("t6_I", 32'({I3, I2, I1, I0}), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #2;
            chk("t6_restart_S", 32'(S), 32'((k / 4) % 4));
            chk("t6_restart_step", 32'(step), 32'(k % 4 == 0));
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) ch_mask = 4'($urandom);
            load      = ($urandom_range(0, 3) == 0);
            load_ch   = 2'($urandom);
            load_data = 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_S", 32'(S), 32'd0);
                chk("rnd_rst_busy", 32'(busy), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
